// File: rtl/ltc2308_scan.sv
// ltc2308_scan -- round-robin scanner for an LTC2308 SPI ADC.
//
// Each frame is CONV (CONVST pulse) -> SHIFT (12 SCK pulses; config word
// out on SDI, previous result in on SDO) -> EMIT (present one sample).
// The LTC2308 returns the result of the *previous* frame's config, so
// results are tagged with the previous configured channel. The first frame
// after reset or after re-enable is a priming frame and emits nothing.
//
// Parameters: NUM_CH (1..8), SCK_DIV (clk cycles per SCK half-period),
//             CONV_CYC (clk cycles CONVST is held high).
// Ports:
//   CLK_50, reset (async, active high), en (scan enable)
//   ADC_CONVST, ADC_SCK, ADC_SDI (outputs to ADC), ADC_SDO (from ADC)
//   out_valid/out_ready handshake, out_ch[2:0], out_data[11:0]
//   sweep_done: high in the cycle the last channel's sample is accepted
//
// Optional build macro: LTC2308_AVG4_EN -- convert each channel four times
// back to back and emit the truncated average of the four results.
module ltc2308_scan #(
  parameter int NUM_CH   = 8,
  parameter int SCK_DIV  = 2,
  parameter int CONV_CYC = 80
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        en,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        ADC_SDI,
  input  logic        ADC_SDO,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_ch,
  output logic [11:0] out_data,
  output logic        sweep_done
);

  localparam int CW = $clog2(CONV_CYC + 1);
  localparam int DW = $clog2(SCK_DIV + 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, EMIT} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_conv_cnt;
  logic [DW-1:0]  r_div_cnt;
  logic [3:0]     r_bit;
  logic           r_convst;
  logic           r_sck;
  logic           r_sdi;
  logic           r_valid;
  logic           r_prime;
  logic [11:0]    r_cfg_sr;
  logic [11:0]    r_shift;
  logic [11:0]    r_data;
  logic [2:0]     r_ch;
  logic [2:0]     r_prev_ch;
  logic [2:0]     r_out_ch;

  logic [2:0]     w_ch_next;
  logic [11:0]    w_cfg_word;

  // Config word MSB first: S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0.
  assign w_cfg_word = {1'b1, r_ch[0], r_ch[2], r_ch[1], 1'b1, 1'b0, 6'b0};
  assign w_ch_next  = (r_ch == 3'(NUM_CH - 1)) ? 3'd0 : r_ch + 3'd1;

`ifdef LTC2308_AVG4_EN
  logic [13:0] r_acc;
  logic [1:0]  r_rep;    // conversions issued with the current config
  logic [1:0]  r_nres;   // results already summed for the pending sample
  logic [13:0] w_sum;
  assign w_sum = r_acc + {2'b00, r_shift};
`endif

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_conv_cnt <= '0;
      r_div_cnt  <= '0;
      r_bit      <= '0;
      r_convst   <= 1'b0;
      r_sck      <= 1'b0;
      r_sdi      <= 1'b0;
      r_valid    <= 1'b0;
      r_prime    <= 1'b1;
      r_cfg_sr   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_ch       <= '0;
      r_prev_ch  <= '0;
      r_out_ch   <= '0;
`ifdef LTC2308_AVG4_EN
      r_acc      <= '0;
      r_rep      <= '0;
      r_nres     <= '0;
`endif
    end else begin
      if (r_valid && out_ready) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          // Any idle cycle with en low restarts the pipeline at channel 0.
          if (!en) begin
            r_prime <= 1'b1;
            r_ch    <= '0;
`ifdef LTC2308_AVG4_EN
            r_acc   <= '0;
            r_rep   <= '0;
            r_nres  <= '0;
`endif
          end
          // A held sample blocks the next conversion so nothing is overwritten.
          if (en && !r_valid) begin
            r_state    <= CONV;
            r_convst   <= 1'b1;
            r_conv_cnt <= '0;
          end
        end

        CONV: begin
          if (r_conv_cnt == CW'(CONV_CYC - 1)) begin
            r_convst  <= 1'b0;
            r_state   <= SHIFT;
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit     <= '0;
            r_sdi     <= w_cfg_word[11];
            r_cfg_sr  <= {w_cfg_word[10:0], 1'b0};
          end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (r_div_cnt == DW'(SCK_DIV - 1)) begin
            r_div_cnt <= '0;
            if (!r_sck) begin
              r_sck   <= 1'b1;
              r_shift <= {r_shift[10:0], ADC_SDO};
            end else begin
              r_sck <= 1'b0;
              if (r_bit == 4'd11) begin
                r_sdi     <= 1'b0;
                r_prev_ch <= r_ch;
                r_prime   <= 1'b0;
`ifdef LTC2308_AVG4_EN
                r_rep <= r_rep + 2'd1;
                if (r_rep == 2'd3) r_ch <= w_ch_next;
                if (r_prime) begin
                  r_state <= IDLE;
                end else if (r_nres == 2'd3) begin
                  r_out_ch <= r_prev_ch;
                  r_data   <= w_sum[13:2];
                  r_acc    <= '0;
                  r_nres   <= '0;
                  r_state  <= EMIT;
                end else begin
                  r_acc   <= w_sum;
                  r_nres  <= r_nres + 2'd1;
                  r_state <= IDLE;
                end
`else
                r_ch <= w_ch_next;
                if (r_prime) begin
                  r_state <= IDLE;
                end else begin
                  r_out_ch <= r_prev_ch;
                  r_data   <= r_shift;
                  r_state  <= EMIT;
                end
`endif
              end else begin
                // SDI only moves on the falling SCK edge.
                r_bit    <= r_bit + 4'd1;
                r_sdi    <= r_cfg_sr[11];
                r_cfg_sr <= {r_cfg_sr[10:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        EMIT: begin
          r_valid <= 1'b1;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign ADC_CONVST = r_convst;
  assign ADC_SCK    = r_sck;
  assign ADC_SDI    = r_sdi;
  assign out_valid  = r_valid;
  assign out_ch     = r_out_ch;
  assign out_data   = r_data;
  assign sweep_done = r_valid & out_ready & (r_out_ch == 3'(NUM_CH - 1));

endmodule

// File: doc/ltc2308_scan.md
LTC2308_SCAN -- requirements
Module: ltc2308_scan

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of single-ended channels scanned 0..NUM_CH-1 (legal 1..8).
REQ-002 SHALL have parameter SCK_DIV, default 2, CLK_50 cycles per SCK half-period (legal >=1).
REQ-003 SHALL have parameter CONV_CYC, default 80, CLK_50 cycles ADC_CONVST is held high per conversion (legal >=2).
REQ-004 SHALL have ports, clock and reset first:
  CLK_50  input  1  system clock.
  reset  input  1  asynchronous, active-high reset.
  en  input  1  scan enable.
  ADC_CONVST  output  1  LTC2308 conversion start.
  ADC_SCK  output  1  LTC2308 serial clock.
  ADC_SDI  output  1  LTC2308 config word, MSB first.
  ADC_SDO  input  1  LTC2308 result, MSB first.
  out_valid  output  1  sample available.
  out_ready  input  1  consumer accepts sample.
  out_ch  output  3  channel of out_data.
  out_data  output  12  unsigned conversion result.
  sweep_done  output  1  one-cycle pulse when channel NUM_CH-1 is accepted.

Function
REQ-005 SHALL implement states IDLE, CONV, SHIFT, EMIT, one frame per pass CONV->SHIFT->EMIT.
REQ-006 IDLE->CONV SHALL occur when en=1 and out_valid=0; otherwise SHALL remain in IDLE.
REQ-007 In CONV, ADC_CONVST SHALL be 1 for exactly CONV_CYC cycles, then 0, then -> SHIFT.
REQ-008 SHIFT SHALL produce exactly 12 SCK pulses, each SCK_DIV cycles low then SCK_DIV cycles high, with SCK idle low.
REQ-009 ADC_SDI SHALL change only while SCK is low. Bits 1..6 SHALL carry config {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0}. ADC_SDI SHALL be 0 for bits 7..12.
REQ-010 ADC_SDO SHALL be sampled in the cycle SCK rises, shifted MSB first into a 12-bit register.
REQ-011 The result shifted in frame k SHALL be attributed to the channel configured in frame k-1 (pipelined ADC config). The first frame after reset or after en re-assertion from IDLE SHALL be a priming frame: it SHALL NOT emit and SHALL go directly to IDLE/CONV.
REQ-012 EMIT SHALL set out_valid=1 with out_ch/out_data stable. These SHALL hold unchanged until the out_valid&out_ready cycle, which SHALL clear out_valid the next cycle. The state SHALL then return to IDLE.
REQ-013 Configured channel SHALL advance 0,1,...,NUM_CH-1,0 (wrap) after each SHIFT. With NUM_CH=1 it SHALL stay 0.
REQ-014 sweep_done SHALL pulse high for exactly the cycle in which a sample with out_ch=NUM_CH-1 is accepted.
REQ-015 Deasserting en mid-frame SHALL complete the current frame including EMIT. No new CONV SHALL start. The next enable SHALL begin with a priming frame at channel 0.
REQ-016 Back-pressure: a held out_valid with out_ready=0 SHALL stall the scanner in EMIT/IDLE with no sample loss or overwrite.
REQ-017 ADC_CONVST and ADC_SCK SHALL never be high in the same cycle.

Reset
REQ-018 While reset=1: state SHALL be IDLE; ADC_CONVST, ADC_SCK, ADC_SDI, out_valid, sweep_done SHALL be 0; out_ch and out_data SHALL be 0; channel pointer SHALL be 0; priming flag SHALL be set.
REQ-019 Reset asserted mid-frame SHALL abort immediately (SCK/CONVST low asynchronously). The pending sample SHALL be discarded.

Configuration
REQ-020 Macro LTC2308_AVG4_EN defined: each channel SHALL be converted 4 consecutive times, with the same config word repeated. out_data SHALL be the 14-bit sum of the 4 results, right-shifted by 2 (truncate). One emit SHALL occur per channel. Priming rules SHALL apply per channel change.
REQ-021 Macro LTC2308_AVG4_EN undefined: one conversion SHALL occur per channel per emit, and no accumulator logic SHALL be present.

Verification
REQ-022 Reset, en=1, out_ready=1, NUM_CH=8, SDO model returns 0x100+ch -> out_ch 0..7 in order with out_data 0x100..0x107, sweep_done once per 8 samples.
REQ-023 Check SPI timing, SCK_DIV=2 -> 12 SCK pulses of period 4 cycles, CONVST high exactly 80 cycles, and SDI config for ch5 = 1,1,1,0,1,0.
REQ-024 Hold out_ready=0 for 500 cycles after first out_valid -> no CONVST pulse, out_data/out_ch stable. Release -> sequence continues without gap or duplicate.
REQ-025 Drop en during SHIFT of ch3 frame -> that sample emitted, then idle. Re-enable -> one priming frame (no emit), then ch0 emitted.
REQ-026 Assert reset during SHIFT -> SCK/CONVST/out_valid 0 same cycle. After release, en=1 -> first emitted sample is ch0.
REQ-027 With LTC2308_AVG4_EN, NUM_CH=2, SDO returns 10,11,12,14 for ch0 -> out_data=11, then ch1 processed.
